lap_stop_watch: RTL and testbench

- Parametrised next-generation stopwatch for the digital clock ASIC. Counts MM:SS from an internal one-second prescaler.
- Separate start/stop, lap and clear buttons drive an explicit state machine.
- Each lap capture freezes the display and stores the time in a lap FIFO. Downstream display/UART logic drains the FIFO with a read strobe.
- Sits beside the clock/alarm blocks under the mode controller, which gates it with stop_watch_en.

---
 rtl/lap_stop_watch.sv | 207 ++++++++++++++++++++
 tb/tb_lap_stop_watch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lap_stop_watch.sv
// MM:SS stopwatch with an internal one-second prescaler, split (frozen) display
// and a first-word-fall-through lap FIFO drained by the display/UART logic.
module lap_stop_watch #(
  parameter int CYCLES_PER_SEC = 1000,
  parameter int MAX_MINUTES    = 59,
  parameter int MIN_W          = 6,
  parameter int LAP_DEPTH      = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stop_watch_en,
  input  logic                             start_stop_button,
  input  logic                             lap_button,
  input  logic                             clear_button,
  input  logic                             lap_rd_en,
  output logic [MIN_W-1:0]                 o_minutes,
  output logic [5:0]                       o_seconds,
  output logic                             o_running,
  output logic                             o_frozen,
  output logic                             lap_valid,
  output logic [MIN_W-1:0]                 lap_minutes,
  output logic [5:0]                       lap_seconds,
  output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_count,
  output logic                             lap_overflow,
  output logic                             stop_watch_ack_flag
);

  localparam int PW = $clog2(CYCLES_PER_SEC);
  localparam int AW = $clog2(LAP_DEPTH);
  localparam int CW = $clog2(LAP_DEPTH + 1);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(CYCLES_PER_SEC - 1);
  localparam logic [MIN_W-1:0] MIN_LAST   = MIN_W'(MAX_MINUTES);
  localparam logic [CW-1:0]    DEPTH_C    = CW'(LAP_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_SPLIT  = 2'd2,
    S_PAUSED = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic [MIN_W-1:0] frz_min_q, frz_min_d;
  logic [5:0]       frz_sec_q, frz_sec_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             ack_q, ack_d;
  logic [MIN_W-1:0] min_mem_q [LAP_DEPTH];
  logic [5:0]       sec_mem_q [LAP_DEPTH];

  logic act_clear, act_start, act_lap;
  logic counting, tick;
  logic fifo_full, fifo_empty, do_push, do_pop;

  // Only the highest-priority pressed button is considered; if it is not
  // meaningful in the current state, the cycle carries no action at all.
  always_comb begin
    act_clear = 1'b0;
    act_start = 1'b0;
    act_lap   = 1'b0;
    if (stop_watch_en) begin
      if (clear_button) begin
        act_clear = (state_q == S_PAUSED);
      end else if (start_stop_button) begin
        act_start = 1'b1;
      end else if (lap_button) begin
        act_lap = (state_q == S_RUN) || (state_q == S_SPLIT);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (act_clear) begin
      state_d = S_IDLE;
    end else if (act_start) begin
      case (state_q)
        S_IDLE:   state_d = S_RUN;
        S_RUN:    state_d = S_PAUSED;
        S_SPLIT:  state_d = S_PAUSED;
        S_PAUSED: state_d = S_RUN;
        default:  state_d = S_IDLE;
      endcase
    end else if (act_lap) begin
      state_d = S_SPLIT;
    end
  end

  assign counting = stop_watch_en && ((state_q == S_RUN) || (state_q == S_SPLIT));
  assign tick     = counting && (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q;
    if (act_clear || tick) begin
      presc_d = '0;
    end else if (counting) begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_comb begin
    min_d = min_q;
    sec_d = sec_q;
    if (act_clear) begin
      min_d = '0;
      sec_d = '0;
    end else if (tick) begin
      if (sec_q == 6'd59) begin
        sec_d = '0;
        min_d = (min_q == MIN_LAST) ? '0 : min_q + 1'b1;
      end else begin
        sec_d = sec_q + 1'b1;
      end
    end
  end

  // Capture takes the pre-tick counter value, matching what the FIFO stores.
  always_comb begin
    frz_min_d = frz_min_q;
    frz_sec_d = frz_sec_q;
    if (act_clear) begin
      frz_min_d = '0;
      frz_sec_d = '0;
    end else if (act_lap) begin
      frz_min_d = min_q;
      frz_sec_d = sec_q;
    end
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign do_pop     = stop_watch_en && lap_rd_en && !fifo_empty && !act_clear;
  assign do_push    = act_lap && (!fifo_full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (act_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{(CW-1){1'b0}}, do_push} - {{(CW-1){1'b0}}, do_pop};
      if (act_lap && fifo_full && !do_pop) ovf_d = 1'b1;
    end
  end

  assign ack_d = stop_watch_en ? act_clear : ack_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      frz_min_q <= '0;
      frz_sec_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      frz_min_q <= frz_min_d;
      frz_sec_q <= frz_sec_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      ack_q     <= ack_d;
    end
  end

  // Lap storage carries no reset; empty entries are masked at the outputs.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      min_mem_q[wr_ptr_q] <= min_q;
      sec_mem_q[wr_ptr_q] <= sec_q;
    end
  end

  assign o_minutes           = (state_q == S_SPLIT) ? frz_min_q : min_q;
  assign o_seconds           = (state_q == S_SPLIT) ? frz_sec_q : sec_q;
  assign o_running           = (state_q == S_RUN) || (state_q == S_SPLIT);
  assign o_frozen            = (state_q == S_SPLIT);
  assign lap_valid           = !fifo_empty;
  assign lap_minutes         = fifo_empty ? '0 : min_mem_q[rd_ptr_q];
  assign lap_seconds         = fifo_empty ? '0 : sec_mem_q[rd_ptr_q];
  assign lap_count           = count_q;
  assign lap_overflow        = ovf_q;
  assign stop_watch_ack_flag = ack_q;

endmodule

// File: tb/tb_lap_stop_watch.sv
// Randomised and directed bench for lap_stop_watch against a behavioural model
// that tracks elapsed time as total seconds and the lap FIFO as a queue.
module tb_lap_stop_watch;
  localparam int C    = 4;
  localparam int MAXM = 59;
  localparam int MW   = 6;
  localparam int D    = 4;
  localparam int HOUR = 60 * (MAXM + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, en = 1'b0, ss = 1'b0, lap = 1'b0, clr = 1'b0, rd = 1'b0;
  logic [MW-1:0] o_minutes, lap_minutes;
  logic [5:0]    o_seconds, lap_seconds;
  logic          o_running, o_frozen, lap_valid, lap_overflow, ack;
  logic [2:0]    lap_count;

  lap_stop_watch #(
    .CYCLES_PER_SEC(C), .MAX_MINUTES(MAXM), .MIN_W(MW), .LAP_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .stop_watch_en(en),
    .start_stop_button(ss), .lap_button(lap), .clear_button(clr), .lap_rd_en(rd),
    .o_minutes(o_minutes), .o_seconds(o_seconds), .o_running(o_running),
    .o_frozen(o_frozen), .lap_valid(lap_valid), .lap_minutes(lap_minutes),
    .lap_seconds(lap_seconds), .lap_count(lap_count), .lap_overflow(lap_overflow),
    .stop_watch_ack_flag(ack)
  );

  int checks = 0;
  int failures = 0;

  // Model: elapsed time in seconds, phase within the current second.
  int m_t, m_ph, m_frz;
  bit m_run, m_split, m_paused, m_ovf, m_ack;
  int m_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_ph = 0; m_frz = 0;
    m_run = 0; m_split = 0; m_paused = 0; m_ovf = 0; m_ack = 0;
    m_q.delete();
  endtask

  task automatic model_step(input bit r, e, s, l, c, p);
    bit was_run, flush, push;
    int cur;
    if (r) begin
      model_reset();
      return;
    end
    if (!e) return;
    was_run = m_run;
    cur = m_t;
    flush = 0;
    push = 0;
    m_ack = 0;
    if (c) begin
      if (m_paused) begin
        m_t = 0; m_ph = 0; m_frz = 0; m_ovf = 0; m_paused = 0;
        m_q.delete();
        m_ack = 1;
        flush = 1;
      end
    end else if (s) begin
      if (m_run) begin
        m_run = 0; m_split = 0; m_paused = 1;
      end else begin
        m_run = 1; m_paused = 0;
      end
    end else if (l) begin
      if (m_run) begin
        m_split = 1; m_frz = cur; push = 1;
      end
    end
    if (!flush && p && m_q.size() > 0) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < D) m_q.push_back(cur);
      else m_ovf = 1;
    end
    if (was_run) begin
      if (m_ph == C - 1) begin
        m_ph = 0;
        m_t = (m_t + 1) % HOUR;
      end else begin
        m_ph++;
      end
    end
  endtask

  task automatic compare_all();
    int shown, head;
    shown = m_split ? m_frz : m_t;
    head  = (m_q.size() > 0) ? m_q[0] : 0;
    chk("minutes",  o_minutes,    shown / 60);
    chk("seconds",  o_seconds,    shown % 60);
    chk("running",  o_running,    m_run);
    chk("frozen",   o_frozen,     m_split);
    chk("lap_valid", lap_valid,   m_q.size() > 0);
    chk("lap_min",  lap_minutes,  head / 60);
    chk("lap_sec",  lap_seconds,  head % 60);
    chk("lap_count", lap_count,   m_q.size());
    chk("overflow", lap_overflow, m_ovf);
    chk("ack",      ack,          m_ack);
  endtask

  task automatic cyc(input bit r, e, s, l, c, p);
    rst = r; en = e; ss = s; lap = l; clr = c; rd = p;
    @(posedge clk);
    model_step(r, e, s, l, c, p);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 1, 1);

    // Basic counting: 16 running cycles give four seconds.
    cyc(0, 1, 1, 0, 0, 0);
    idle_n(16);
    chk("t1_sec", o_seconds, 4);
    chk("t1_run", o_running, 1);

    // Laps, split display, FIFO order and pop.
    idle_n(3);
    cyc(0, 1, 0, 1, 0, 0);
    idle_n(12);
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 1);
    // Fill past depth, then lap with pop while full.
    for (int k = 0; k < 4; k++) begin
      idle_n(5);
      cyc(0, 1, 0, 1, 0, 0);
    end
    cyc(0, 1, 0, 1, 0, 1);
    chk("full_cnt", lap_count, 4);

    // Start+lap together, enable low, clear rules.
    cyc(0, 1, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 1, 1);
    cyc(0, 1, 1, 0, 0, 0);
    idle_n(2);
    cyc(0, 1, 1, 0, 0, 0);
    idle_n(3);
    cyc(0, 1, 1, 0, 0, 0);
    idle_n(6);
    cyc(0, 1, 0, 0, 1, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 0);
    chk("clr_ack", ack, 1);
    chk("clr_cnt", lap_count, 0);
    idle_n(2);

    // Reset during split.
    cyc(0, 1, 1, 0, 0, 0);
    idle_n(5);
    cyc(0, 1, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("rst_frozen", o_frozen, 0);

    // Full-hour run through the silent wrap.
    cyc(0, 1, 1, 0, 0, 0);
    idle_n(3599 * C);
    chk("wrap_pre_m", o_minutes, 59);
    chk("wrap_pre_s", o_seconds, 59);
    idle_n(C);
    chk("wrap_m", o_minutes, 0);
    chk("wrap_s", o_seconds, 0);
    chk("wrap_run", o_running, 1);

    // Random traffic.
    for (int i = 0; i < 6000; i++) begin
      bit r, e, s, l, c, p;
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 9) != 0);
      s = ($urandom_range(0, 11) == 0);
      l = ($urandom_range(0, 5) == 0);
      c = ($urandom_range(0, 9) == 0);
      p = ($urandom_range(0, 5) == 0);
      cyc(r, e, s, l, c, p);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
